// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S stream transmitter.
package i2s_pkg;

    // Transmitter sequencing: idle, waiting for a left-slot boundary, streaming.
    typedef enum logic [1:0] {
        StIdle,
        StWaitL,
        StRun
    } tx_state_e;

    // Width of the optional silent-frame counter.
    localparam int unsigned UNDERRUN_CNT_W = 16;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        return (&v) ? v : v + UNDERRUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/i2s_tx_stream_fifo.sv
// Synchronous frame FIFO: pointer-based storage with an extra wrap bit to tell full from empty.
// Read data is presented combinationally from the head entry (first-word fall-through).
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      ptr_diff;
    logic             do_push;
    logic             do_pop;

    assign ptr_diff = wr_ptr_q - rd_ptr_q;
    assign level    = LW'(ptr_diff);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    // Advance write/read pointers on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/i2s_tx_stream.sv
// I2S stereo transmitter with frame FIFO, fully in the CLK domain.
// SCLK/LRCLK are synchronised and edge-detected; data changes after the detected SCLK fall.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds a saturating silent-frame counter port.
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                              CLK,
    input  logic                              RESET_N,
    input  logic                              en,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [SAMPLE_W-1:0]               wr_left,
    input  logic [SAMPLE_W-1:0]               wr_right,
    input  logic                              SCLK,
    input  logic                              LRCLK,
    output logic                              Dout,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              underrun,
    input  logic                              underrun_clr
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0]         underrun_cnt
`endif
);

    localparam int unsigned PAD_W = SLOT_W - SAMPLE_W;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } frame_t;

    // Pin capture and edge detection
    logic sclk_meta, sclk_sync, sclk_d;
    logic lr_meta, lr_sync;
    logic lr_q, lr_prev;
    logic sclk_rise, sclk_fall;
    logic slot_start, left_start, right_start;

    // FIFO interface
    frame_t fifo_wdata, fifo_rdata, load_frame;
    logic   fifo_full, fifo_empty;
    logic   push, pop;

    // Transmit datapath
    tx_state_e         state_q;
    frame_t            hold_q;
    logic [SLOT_W-1:0] shift_q;
    logic [SLOT_W-1:0] left_word, right_word;
    logic              load_left;
    logic              underrun_set;

    // Two-flop synchronisers plus a delayed SCLK copy for edge detection.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_d    <= 1'b0;
            lr_meta   <= 1'b0;
            lr_sync   <= 1'b0;
        end else begin
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            lr_meta   <= LRCLK;
            lr_sync   <= lr_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_d;
    assign sclk_fall = ~sclk_sync & sclk_d;

    // Word select sampled on SCLK rise, remembered on SCLK fall; a change marks a slot start.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lr_q    <= 1'b0;
            lr_prev <= 1'b0;
        end else begin
            if (sclk_rise) lr_q    <= lr_sync;
            if (sclk_fall) lr_prev <= lr_q;
        end
    end

    assign slot_start  = sclk_fall & (lr_q != lr_prev);
    assign left_start  = slot_start & ~lr_q;
    assign right_start = slot_start & lr_q;

    assign fifo_wdata = '{l: wr_left, r: wr_right};
    assign wr_ready   = ~fifo_full;
    assign push       = wr_valid & wr_ready;

    // A left boundary while enabled and past IDLE begins a new frame (real or silent).
    assign load_left    = left_start & en & (state_q != StIdle);
    assign pop          = load_left & ~fifo_empty;
    assign underrun_set = load_left & fifo_empty;
    assign load_frame   = fifo_empty ? '0 : fifo_rdata;

    // Samples are left-justified in the slot; the pad below them is zero.
    assign left_word  = SLOT_W'(load_frame.l) << PAD_W;
    assign right_word = SLOT_W'(hold_q.r) << PAD_W;

    sync_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .push      (push),
        .push_data (fifo_wdata),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Sticky underrun flag; a new silent frame wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            underrun <= 1'b0;
        end else if (underrun_set) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating silent-frame count, cleared with the flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            underrun_cnt <= '0;
        end else if (underrun_set) begin
            underrun_cnt <= underrun_clr ? UNDERRUN_CNT_W'(1) : sat_inc(underrun_cnt);
        end else if (underrun_clr) begin
            underrun_cnt <= '0;
        end
    end
`endif

    // Transmit sequencer: frame load at left boundaries, right reload, bit shifting.
    // The shifter holds the bits still to be sent after the one currently on Dout.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            hold_q  <= '0;
            shift_q <= '0;
            Dout    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    Dout <= 1'b0;
                    if (en) state_q <= StWaitL;
                end
                StWaitL: begin
                    Dout <= 1'b0;
                    if (!en) begin
                        state_q <= StIdle;
                    end else if (load_left) begin
                        state_q <= StRun;
                        hold_q  <= load_frame;
                        shift_q <= left_word << 1;
                        Dout    <= left_word[SLOT_W-1];
                    end
                end
                StRun: begin
                    if (left_start) begin
                        if (en) begin
                            hold_q  <= load_frame;
                            shift_q <= left_word << 1;
                            Dout    <= left_word[SLOT_W-1];
                        end else begin
                            // Frame finished with its right slot; stop cleanly here.
                            state_q <= StIdle;
                            shift_q <= '0;
                            Dout    <= 1'b0;
                        end
                    end else if (right_start) begin
                        shift_q <= right_word << 1;
                        Dout    <= right_word[SLOT_W-1];
                    end else if (sclk_fall) begin
                        shift_q <= shift_q << 1;
                        Dout    <= shift_q[SLOT_W-1];
                    end
                end
                default: begin
                    state_q <= StIdle;
                    Dout    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed bench for i2s_tx_stream (SAMPLE_W=24, SLOT_W=32, FIFO_DEPTH=8).
// Bench drives SCLK/LRCLK as an I2S master; LRCLK changes on SCLK fall.
module tb_i2s_tx_stream;

    logic        CLK          = 1'b0;
    logic        RESET_N      = 1'b0;
    logic        en           = 1'b0;
    logic        wr_valid     = 1'b0;
    logic        wr_ready;
    logic [23:0] wr_left      = '0;
    logic [23:0] wr_right     = '0;
    logic        SCLK         = 1'b1;
    logic        LRCLK        = 1'b0;
    logic        Dout;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic        underrun_clr = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [63:0] hist   = '0;
    logic [31:0] lw;
    logic [31:0] rw;
    logic        acc;

    always #5 CLK = ~CLK;

    i2s_tx_stream #(
        .SAMPLE_W   (24),
        .SLOT_W     (32),
        .FIFO_DEPTH (8)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .en           (en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_left      (wr_left),
        .wr_right     (wr_right),
        .SCLK         (SCLK),
        .LRCLK        (LRCLK),
        .Dout         (Dout),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SCLK period: fall (LRCLK updated), 8 CLK low, sample Dout, rise, 8 CLK high.
    task automatic bit_clk(input logic lr);
        @(negedge CLK);
        SCLK  = 1'b0;
        LRCLK = lr;
        repeat (8) @(negedge CLK);
        hist = {hist[62:0], Dout};
        SCLK = 1'b1;
        repeat (7) @(negedge CLK);
    endtask

    task automatic write(input logic [23:0] l, input logic [23:0] r, output logic a);
        @(negedge CLK);
        wr_valid = 1'b1;
        wr_left  = l;
        wr_right = r;
        a        = wr_ready;
        @(negedge CLK);
        wr_valid = 1'b0;
    endtask

    // evt 1: drop en; evt 2: pulse reset mid-slot and check immediate effect.
    task automatic do_event(input int evt);
        if (evt == 1) begin
            en = 1'b0;
        end else if (evt == 2) begin
            check("dout_before_reset", 32'(Dout), 32'h1);
            RESET_N = 1'b0;
            #1;
            check("dout_in_reset", 32'(Dout), 32'h0);
            check("level_in_reset", 32'(fifo_level), 32'h0);
            check("ready_in_reset", 32'(wr_ready), 32'h1);
            @(negedge CLK);
            RESET_N = 1'b1;
        end
    endtask

    // One frame of n SCLK per half; assumes the left-half first bit (pos 0) was already sent.
    // Each word is the n bits starting one SCLK after its LRCLK edge.
    task automatic frame(input int n, input int evt_at, input int evt,
                         output logic [31:0] l_w, output logic [31:0] r_w);
        logic [63:0] mask;
        mask = (64'h1 << n) - 64'h1;
        for (int i = 0; i < n - 1; i++) begin
            if (i == evt_at) do_event(evt);
            bit_clk(1'b0);
        end
        bit_clk(1'b1);
        l_w = 32'(hist & mask);
        for (int i = 0; i < n - 1; i++) bit_clk(1'b1);
        bit_clk(1'b0);
        r_w = 32'(hist & mask);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_dout", 32'(Dout), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h1);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Fill FIFO with SCLK stopped
        write(24'hA5A5A5, 24'h123456, acc);
        check("wr0_acc", 32'(acc), 32'h1);
        write(24'h800001, 24'h7FFFFE, acc);
        write(24'h0F0F0F, 24'hF0F0F0, acc);
        write(24'h000001, 24'hFFFFFF, acc);
        write(24'h5A5A5A, 24'h3C3C3C, acc);
        write(24'h123123, 24'h456456, acc);
        write(24'h800000, 24'h000001, acc);
        write(24'h7FFFFF, 24'h800000, acc);
        check("wr7_acc", 32'(acc), 32'h1);
        check("full_level", 32'(fifo_level), 32'h8);
        check("full_ready", 32'(wr_ready), 32'h0);
        write(24'hDEADBE, 24'hEF0123, acc);
        check("wr8_rejected", 32'(acc), 32'h0);
        check("full_level_kept", 32'(fifo_level), 32'h8);

        // Start streaming: a right slot first (ignored), then left pos 0
        en = 1'b1;
        bit_clk(1'b1);
        bit_clk(1'b1);
        bit_clk(1'b0);
        frame(32, -1, 0, lw, rw);
        check("f0_left", lw, 32'hA5A5A500);
        check("f0_right", rw, 32'h12345600);
        check("after_pop_level", 32'(fifo_level), 32'h7);
        check("after_pop_ready", 32'(wr_ready), 32'h1);
        frame(32, -1, 0, lw, rw);
        check("f1_left", lw, 32'h80000100);
        check("f1_right", rw, 32'h7FFFFE00);
        frame(32, -1, 0, lw, rw);
        check("f2_left", lw, 32'h0F0F0F00);
        check("f2_right", rw, 32'hF0F0F000);
        frame(32, -1, 0, lw, rw);
        check("f3_left", lw, 32'h00000100);
        check("f3_right", rw, 32'hFFFFFF00);

        // en dropped mid-frame: frame completes, then silence with FIFO intact
        frame(32, 5, 1, lw, rw);
        check("f4_left", lw, 32'h5A5A5A00);
        check("f4_right", rw, 32'h3C3C3C00);
        frame(32, -1, 0, lw, rw);
        check("idle_left", lw, 32'h0);
        check("idle_right", rw, 32'h0);
        check("idle_level", 32'(fifo_level), 32'h3);
        check("idle_underrun", 32'(underrun), 32'h0);

        // en raised during a right slot: silent until the next left slot
        repeat (31) bit_clk(1'b0);
        bit_clk(1'b1);
        en = 1'b1;
        repeat (31) bit_clk(1'b1);
        bit_clk(1'b0);
        check("start_phase_silent", 32'(hist), 32'h0);
        frame(32, -1, 0, lw, rw);
        check("f5_left", lw, 32'h12312300);
        check("f5_right", rw, 32'h45645600);
        frame(32, -1, 0, lw, rw);
        check("f6_left", lw, 32'h80000000);
        check("f6_right", rw, 32'h00000100);
        frame(32, -1, 0, lw, rw);
        check("f7_left", lw, 32'h7FFFFF00);
        check("f7_right", rw, 32'h80000000);
        check("drained_level", 32'(fifo_level), 32'h0);
        check("drained_underrun", 32'(underrun), 32'h0);

        // Underrun: silent frames and sticky flag
        frame(32, -1, 0, lw, rw);
        check("ur_left", lw, 32'h0);
        check("ur_right", rw, 32'h0);
        check("ur_flag", 32'(underrun), 32'h1);
        frame(32, -1, 0, lw, rw);
        frame(32, -1, 0, lw, rw);
        check("ur3_left", lw, 32'h0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("ur_cnt3", 32'(underrun_cnt), 32'h3);
`endif
        write(24'h111111, 24'h222222, acc);
        frame(32, -1, 0, lw, rw);
        check("f8_left", lw, 32'h11111100);
        check("f8_right", rw, 32'h22222200);
        check("ur_flag_sticky", 32'(underrun), 32'h1);
        @(negedge CLK);
        underrun_clr = 1'b1;
        @(negedge CLK);
        underrun_clr = 1'b0;
        check("ur_flag_cleared", 32'(underrun), 32'h0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("ur_cnt_cleared", 32'(underrun_cnt), 32'h0);
`endif

        // Short slots: 20 SCLK per half keeps the top 20 bits
        write(24'hABCDEF, 24'h987654, acc);
        write(24'hFFFFFF, 24'h000000, acc);
        frame(20, -1, 0, lw, rw);
        check("short_left", lw, 32'h000ABCDE);
        check("short_right", rw, 32'h00098765);

        // Mid-slot reset, then resume at a later left slot
        frame(20, 8, 2, lw, rw);
        check("post_reset_right", rw, 32'h0);
        check("post_reset_underrun", 32'(underrun), 32'h0);
        write(24'h13579B, 24'h2468AC, acc);
        frame(20, -1, 0, lw, rw);
        check("resume_left", lw, 32'h00013579);
        check("resume_right", rw, 32'h0002468A);
        check("resume_level", 32'(fifo_level), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
